// File: rtl/cmp_pkg.sv
// Shared types and default sizes for the min/max tracker and its comparator.
package cmp_pkg;

  localparam int CMP_W     = 4;
  localparam int CMP_CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CMP_MAX = 3'd2,
    S_CMP_MIN = 3'd3,
    S_DONE    = 3'd4
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_flags_t;

endpackage

// File: rtl/cmp_mag_unit.sv
// Combinational magnitude comparator, zero latency, no flow control.
// CMP_TRACK_SIGNED_EN selects two's-complement ordering; otherwise unsigned.
module cmp_mag_unit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

`ifdef CMP_TRACK_SIGNED_EN
  assign gt = $signed(a) > $signed(b);
  assign lt = $signed(a) < $signed(b);
`else
  assign gt = a > b;
  assign lt = a < b;
`endif
  assign eq = (a == b);

endmodule

// File: rtl/cmp_minmax_tracker.sv
// Running max/min/count/ties over a framed operand stream; one record per frame.
// One sample per 3 cycles after the first; in_ready drops while comparing or holding a record.
module cmp_minmax_tracker
  import cmp_pkg::*;
#(
  parameter int W     = CMP_W,
  parameter int CNT_W = CMP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     max_val,
  output logic [W-1:0]     min_val,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] ties
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  cmp_state_t   state;
  logic [W-1:0] sample_q;
  logic         last_q;
  logic [W-1:0] cmp_b;
  cmp_flags_t   flags;

  assign in_ready = ((state == S_IDLE) || (state == S_WAIT)) && rst_n;

  // The single comparator is shared: B is max_val in S_CMP_MAX, min_val otherwise.
  assign cmp_b = (state == S_CMP_MAX) ? max_val : min_val;

  cmp_mag_unit #(.W(W)) u_cmp (
    .a  (sample_q),
    .b  (cmp_b),
    .gt (flags.gt),
    .eq (flags.eq),
    .lt (flags.lt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sample_q  <= '0;
      last_q    <= 1'b0;
      max_val   <= '0;
      min_val   <= '0;
      count     <= '0;
      ties      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            max_val   <= in_data;
            min_val   <= in_data;
            count     <= CNT_ONE;
            ties      <= '0;
            out_valid <= in_last;
            state     <= in_last ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            sample_q <= in_data;
            last_q   <= in_last;
            if (!(&count)) count <= count + CNT_ONE;
            state    <= S_CMP_MAX;
          end
        end
        S_CMP_MAX: begin
          if (flags.gt) max_val <= sample_q;
          if (flags.eq && !(&ties)) ties <= ties + CNT_ONE;
          state <= S_CMP_MIN;
        end
        S_CMP_MIN: begin
          if (flags.lt) min_val <= sample_q;
          if (last_q) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_DONE: begin
          // Record fields stay as-is after the handshake until the next first sample.
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_minmax_tracker.sv
// Bench for cmp_minmax_tracker: vector table, timing sequences, saturation, random frames vs model.
module tb_cmp_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_last, out_valid, out_ready;
  logic [3:0] in_data, max_val, min_val;
  logic [7:0] count, ties;

  logic       s2_in_valid, s2_in_ready, s2_in_last, s2_out_valid, s2_out_ready;
  logic [3:0] s2_in_data, s2_max_val, s2_min_val;
  logic [1:0] s2_count, s2_ties;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  cmp_minmax_tracker #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .max_val(max_val), .min_val(min_val), .count(count), .ties(ties)
  );

  cmp_minmax_tracker #(.W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s2_in_valid), .in_ready(s2_in_ready),
    .in_data(s2_in_data), .in_last(s2_in_last), .out_valid(s2_out_valid), .out_ready(s2_out_ready),
    .max_val(s2_max_val), .min_val(s2_min_val), .count(s2_count), .ties(s2_ties)
  );

  typedef struct {
    int         n;
    logic [3:0] d[4];
    logic [3:0] emax;
    logic [3:0] emin;
    int         ecnt;
    int         eties;
  } vec_t;

  vec_t tbl[5];

  function automatic bit ref_gt(input logic [3:0] a, input logic [3:0] b);
`ifdef CMP_TRACK_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    vecs++;
    errs++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input int n, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3, input logic [3:0] emax,
                         input logic [3:0] emin, input int ecnt, input int eties);
    tbl[i].n = n;
    tbl[i].d[0] = d0; tbl[i].d[1] = d1; tbl[i].d[2] = d2; tbl[i].d[3] = d3;
    tbl[i].emax = emax; tbl[i].emin = emin; tbl[i].ecnt = ecnt; tbl[i].eties = eties;
  endtask

  // Returns one microstep after the accepting edge.
  task automatic send(input logic [3:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("send");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get_rec(input string nm, input logic [3:0] emax, input logic [3:0] emin,
                         input int ecnt, input int eties, input int hold);
    int n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (n >= 50) timeout({nm, "_out_valid"});
    chk({nm, "_max"}, max_val, emax);
    chk({nm, "_min"}, min_val, emin);
    chk({nm, "_count"}, count, ecnt);
    chk({nm, "_ties"}, ties, eties);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] q[$];
    logic [3:0] m, mn;
    int t, n;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    s2_in_valid = 1'b0; s2_in_data = '0; s2_in_last = 1'b0; s2_out_ready = 1'b0;

    set_vec(0, 3, 4'd12, 4'd10, 4'd5, 4'd0, 4'd12, 4'd5, 3, 0);
    set_vec(1, 3, 4'd5, 4'd5, 4'd5, 4'd0, 4'd5, 4'd5, 3, 2);
    set_vec(2, 1, 4'd9, 4'd0, 4'd0, 4'd0, 4'd9, 4'd9, 1, 0);
`ifdef CMP_TRACK_SIGNED_EN
    set_vec(3, 2, 4'b1100, 4'b0010, 4'd0, 4'd0, 4'b0010, 4'b1100, 2, 0);
`else
    set_vec(3, 2, 4'b1100, 4'b0010, 4'd0, 4'd0, 4'b1100, 4'b0010, 2, 0);
`endif
    set_vec(4, 4, 4'd3, 4'd7, 4'd7, 4'd1, 4'd7, 4'd1, 4, 1);

    // Reset state
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_max", max_val, 0);
    chk("rst_min", min_val, 0);
    chk("rst_count", count, 0);
    chk("rst_ties", ties, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < tbl[i].n; j++) send(tbl[i].d[j], j == tbl[i].n - 1);
      get_rec($sformatf("tbl%0d", i), tbl[i].emax, tbl[i].emin, tbl[i].ecnt, tbl[i].eties, i % 3);
    end

    // in_ready timing around non-first accepts, out_valid latency of last sample
    send(4'd12, 1'b0);
    chk("t1_ready_after_first", in_ready, 1);
    send(4'd10, 1'b0);
    chk("t1_ready_c1", in_ready, 0);
    tick(); chk("t1_ready_c2", in_ready, 0);
    tick(); chk("t1_ready_c3", in_ready, 1);
    send(4'd5, 1'b1);
    chk("t1_ov_c1", out_valid, 0);
    tick(); chk("t1_ov_c2", out_valid, 0);
    tick(); chk("t1_ov_c3", out_valid, 1);
    chk("t1_ready_done", in_ready, 0);
    get_rec("t1", 4'd12, 4'd5, 3, 0, 0);

    // Single sample latency and stall in S_DONE
    send(4'd9, 1'b1);
    chk("t3_ov_next", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("t4_stall_ov", out_valid, 1);
      chk("t4_stall_ready", in_ready, 0);
      chk("t4_stall_max", max_val, 9);
      chk("t4_stall_cnt", count, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_ov_after", out_valid, 0);
    chk("t4_ready_after", in_ready, 1);
    chk("t4_cnt_held", count, 1);
    chk("t4_min_held", min_val, 9);

    // Reset in S_CMP_MAX aborts the frame
    send(4'd3, 1'b0);
    send(4'd7, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("t6_ov", out_valid, 0);
    chk("t6_ready", in_ready, 0);
    chk("t6_max", max_val, 0);
    chk("t6_min", min_val, 0);
    chk("t6_count", count, 0);
    chk("t6_ties", ties, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin tick(); chk("t6_no_record", out_valid, 0); end
    send(4'd6, 1'b1);
    get_rec("t6_next", 4'd6, 4'd6, 1, 0, 0);

    // Saturation with CNT_W=2
    for (int k = 0; k < 5; k++) begin
      n = 0;
      s2_in_valid = 1'b1; s2_in_data = 4'd0; s2_in_last = (k == 4);
      while (!s2_in_ready && n < 50) begin tick(); n++; end
      if (n >= 50) timeout("t7_send");
      tick();
      s2_in_valid = 1'b0;
    end
    n = 0;
    while (!s2_out_valid && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("t7_out_valid");
    chk("t7_count_sat", s2_count, 3);
    chk("t7_ties_sat", s2_ties, 3);
    s2_out_ready = 1'b1;
    tick();
    s2_out_ready = 1'b0;

    // Random frames against the model
    for (int f = 0; f < 40; f++) begin
      q.delete();
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) q.push_back(4'($urandom_range(0, 15)));
      m = q[0]; mn = q[0]; t = 0;
      for (int j = 1; j < n; j++) begin
        if (q[j] == m) t++;
        if (ref_gt(q[j], m)) m = q[j];
        if (ref_gt(mn, q[j])) mn = q[j];
      end
      for (int j = 0; j < n; j++) begin
        send(q[j], j == n - 1);
        repeat ($urandom_range(0, 2)) tick();
      end
      get_rec($sformatf("rnd%0d", f), m, mn, n, t, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
